// File: rtl/zhadan_jianpan.sv
// zhadan_jianpan: 4x4 matrix keypad scanner for defuse-code entry.
//
// Drives the keypad rows one at a time (active-low, one-hot) and reads the
// columns back. A full 16-bit snapshot is built over one scan frame. Presses and
// releases are only accepted after DEBOUNCE_SCANS identical frames. Frames with
// two or more keys down are treated as empty, so ghost patterns are rejected.
//
// Parameters:
//   SCAN_DIV        clk cycles each row is driven (>= 4)
//   DEBOUNCE_SCANS  consecutive matching frames to accept press/release (2..15)
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   row        row drive, active-low one-hot (row[i]=0 selects row i)
//   col        column sense, active-low, asynchronous to clk
//   key_code   last accepted key, row_index*4 + col_index
//   key_valid  one-cycle pulse on acceptance of a press
//   key_held   high from press acceptance until release acceptance
module zhadan_jianpan #(
    parameter int unsigned SCAN_DIV       = 2500,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] row,
    input  logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned    DivW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DivW-1:0] DivMax  = DivW'(SCAN_DIV - 1);
    localparam logic [3:0]     DbTarget = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        StIdle,
        StDbPress,
        StPressed,
        StDbRelease
    } state_e;

    // Column synchroniser; reset to the released (pulled-up) level.
    logic [3:0] col_meta_q, col_s_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta_q <= 4'hF;
            col_s_q    <= 4'hF;
        end else begin
            col_meta_q <= col;
            col_s_q    <= col_meta_q;
        end
    end

    // Row dwell divider and row index.
    logic [DivW-1:0] div_q, div_d;
    logic [1:0]      row_idx_q, row_idx_d;
    logic            tick, frame_end;

    assign tick      = (div_q == DivMax);
    assign frame_end = tick && (row_idx_q == 2'd3);

    always_comb begin
        div_d     = div_q + DivW'(1);
        row_idx_d = row_idx_q;
        if (tick) begin
            div_d     = '0;
            row_idx_d = row_idx_q + 2'd1;
        end
    end

    assign row = ~(4'b0001 << row_idx_q);

    // Snapshot: one bit per key, 1 = pressed.
    logic [15:0] snap_q, snap_d;

    always_comb begin
        snap_d = snap_q;
        if (tick) begin
            snap_d[4*row_idx_q +: 4] = ~col_s_q;
        end
    end

    // Classify the completed frame. snap_d already includes the last row, so
    // the decision is made on the same edge the row-3 sample is stored.
    logic [4:0] ones;
    logic [3:0] single_idx;
    logic       single;

    always_comb begin
        ones       = '0;
        single_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (snap_d[i]) begin
                ones       = ones + 5'd1;
                single_idx = 4'(i);
            end
        end
        single = (ones == 5'd1);
    end

    // Debounce FSM.
    state_e     state_q, state_d;
    logic [3:0] cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] code_q, code_d;
    logic       held_q, held_d;
    logic       valid_q, valid_d;
    logic [3:0] cnt_inc;
    logic       match;

    assign cnt_inc = cnt_q + 4'd1;
    assign match   = single && (single_idx == cand_q);

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        held_d  = held_q;
        valid_d = 1'b0;
        if (frame_end) begin
            unique case (state_q)
                StIdle: begin
                    if (single) begin
                        cand_d  = single_idx;
                        cnt_d   = 4'd1;
                        state_d = StDbPress;
                    end
                end
                StDbPress: begin
                    if (match) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DbTarget) begin
                            state_d = StPressed;
                            cnt_d   = '0;
                            code_d  = cand_q;
                            held_d  = 1'b1;
                            valid_d = 1'b1;
                        end
                    end else begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end
                StPressed: begin
                    if (!match) begin
                        state_d = StDbRelease;
                        cnt_d   = 4'd1;
                    end
                end
                StDbRelease: begin
                    if (match) begin
                        state_d = StPressed;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DbTarget) begin
                            state_d = StIdle;
                            cnt_d   = '0;
                            held_d  = 1'b0;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            row_idx_q <= '0;
            snap_q    <= '0;
            state_q   <= StIdle;
            cand_q    <= '0;
            cnt_q     <= '0;
            code_q    <= '0;
            held_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            div_q     <= div_d;
            row_idx_q <= row_idx_d;
            snap_q    <= snap_d;
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            code_q    <= code_d;
            held_q    <= held_d;
            valid_q   <= valid_d;
        end
    end

    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;

endmodule

// File: tb/tb_zhadan_jianpan.sv
// Bench for zhadan_jianpan with SCAN_DIV=4, DEBOUNCE_SCANS=3 (16-cycle frames).
// Expected key codes are queued when a press is started; a monitor pops and
// compares on every key_valid pulse. Levels are checked directly at frame edges.
module tb_zhadan_jianpan;

    localparam int unsigned Frame = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] pressed = '0;
    logic [3:0]  exp_q[$];
    int          checks = 0;
    int          errors = 0;

    zhadan_jianpan #(
        .SCAN_DIV      (4),
        .DEBOUNCE_SCANS(3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .row      (row),
        .col      (col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    // Keypad model: column c pulled low when a driven row has key (r,c) down.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row[r] && pressed[r*4+c]) col[c] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: each key_valid pulse must match the next queued key.
    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got code %0d expected no pulse at %0t",
                         key_code, $time);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (key_code !== e || key_held !== 1'b1) begin
                    errors++;
                    $display("FAIL pulse_code: got code %0d held %b expected code %0d held 1",
                             key_code, key_held, e);
                end
            end
        end
    end

    task automatic frames(input int n);
        repeat (n * Frame) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state and row rotation.
        check("rst_row", row, 4'b1110);
        check("rst_code", key_code, 4'd0);
        check("rst_valid", key_valid, 1'b0);
        check("rst_held", key_held, 1'b0);
        repeat (4) @(negedge clk);
        check("row_4", row, 4'b1101);
        repeat (4) @(negedge clk);
        check("row_8", row, 4'b1011);
        repeat (4) @(negedge clk);
        check("row_12", row, 4'b0111);
        repeat (4) @(negedge clk);
        check("row_16", row, 4'b1110);

        // Clean press of key (1,2) = code 6.
        exp_q.push_back(4'd6);
        pressed = 16'h1 << 6;
        frames(2);
        check("clean_not_yet", key_held, 1'b0);
        frames(1);
        check("clean_held", key_held, 1'b1);
        check("clean_code", key_code, 4'd6);
        frames(3);
        pressed = '0;
        frames(2);
        check("clean_release_wait", key_held, 1'b1);
        frames(1);
        check("clean_released", key_held, 1'b0);

        // Bounce: key (3,3) for two frames only.
        pressed = 16'h1 << 15;
        frames(2);
        pressed = '0;
        frames(2);
        check("bounce_code", key_code, 4'd6);
        check("bounce_held", key_held, 1'b0);

        // Ghost: keys (1,1) and (2,2) together.
        pressed = (16'h1 << 5) | (16'h1 << 10);
        frames(6);
        check("ghost_held", key_held, 1'b0);
        check("ghost_code", key_code, 4'd6);
        pressed = '0;
        frames(1);

        // Release glitch: key (0,0) with a one-frame dropout in frame 6.
        exp_q.push_back(4'd0);
        pressed = 16'h1;
        frames(3);
        check("glitch_held", key_held, 1'b1);
        check("glitch_code", key_code, 4'd0);
        frames(2);
        pressed = '0;
        frames(1);
        check("glitch_dropout_held", key_held, 1'b1);
        pressed = 16'h1;
        frames(4);
        check("glitch_end_held", key_held, 1'b1);

        // Asynchronous reset between clock edges while PRESSED; key stays down.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_row", row, 4'b1110);
        check("arst_held", key_held, 1'b0);
        check("arst_code", key_code, 4'd0);
        check("arst_valid", key_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(4'd0);
        frames(2);
        check("arst_not_yet", key_held, 1'b0);
        frames(1);
        check("arst_repress_held", key_held, 1'b1);
        pressed = '0;
        frames(4);
        check("arst_release", key_held, 1'b0);

        check("pulses_outstanding", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/zhadan_jianpan.md
Name: zhadan_jianpan

Overview:
- 4x4 matrix keypad scanner for the bomb-dismantle game's defuse-code entry.
- Row-drive/column-sense counterpart of the LED matrix driver: this block drives active-low one-hot rows and reads the matrix back.
- Debounces presses over whole scan frames.
- Emits a 4-bit key code with a single-cycle valid pulse per press, and a level for as long as the key is held.

Parameters:
- SCAN_DIV, 2500, clk cycles each row is driven (row dwell); legal range >= 4.
- DEBOUNCE_SCANS, 4, consecutive identical full-scan frames required to accept a press or a release; legal range 2..15.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- row  output  4  row drive, active-low one-hot; row[i]=0 selects keypad row i.
- col  input  4  column sense, active-low (pulled up externally); asynchronous to clk.
- key_code  output  4  code of the last accepted key, equal to row_index*4 + col_index; holds until the next accepted press.
- key_valid  output  1  one-cycle pulse when a press is accepted.
- key_held  output  1  high from acceptance of a press until acceptance of its release.

Behaviour:
- Reset (rst_n=0, acts immediately, no clock needed): row=4'b1110, key_code=0, key_valid=0, key_held=0, divider=0, row index=0, FSM=IDLE, debounce count=0, snapshot cleared. A reset mid-press discards all debounce state; no pulse is generated on exit.
- Input synchroniser: col passes through a 2-flop synchroniser (col_s) before any use.
- Divider: counts 0..SCAN_DIV-1 and wraps. Tick = cycle where count==SCAN_DIV-1.
- On a tick:
  - the inverted col_s is stored into snapshot bits [4*r+3:4*r], where r is the current row index;
  - the row index advances r -> (r+1) mod 4;
  - row is updated on the same edge.
- Row order: 1110 -> 1101 -> 1011 -> 0111 -> 1110. Frame period = 4*SCAN_DIV cycles.
- Frame end = the tick for r=3. The frame is classified from the complete 16-bit snapshot:
  - NONE: no bits set.
  - SINGLE(k): exactly one bit set; k = bit index.
  - MULTI: two or more bits set. MULTI is treated as NONE (ghosting rejected).
- FSM steps only at frame end. It holds cand (4 bits) and cnt (4 bits).
  - IDLE: on SINGLE(k), set cand=k, cnt=1, go to DB_PRESS. Otherwise stay.
  - DB_PRESS, on SINGLE(cand): cnt+1. When cnt+1==DEBOUNCE_SCANS: go to PRESSED, key_code=cand, key_held=1, key_valid=1 for exactly that one cycle.
  - DB_PRESS, on any other classification: go to IDLE, cnt=0. No restart on a different key within the same frame; the next frame restarts from IDLE.
  - PRESSED, on SINGLE(cand): stay.
  - PRESSED, on anything else: go to DB_RELEASE, cnt=1.
  - DB_RELEASE, on SINGLE(cand): go back to PRESSED, cnt=0. No new key_valid, key_held stays 1.
  - DB_RELEASE, on anything else: cnt+1. When cnt+1==DEBOUNCE_SCANS: go to IDLE, key_held=0.
- Latency: key_valid rises on the frame-end edge of the DEBOUNCE_SCANS-th consecutive SINGLE(k) frame (clk edge after the tick is registered).
- Exactly one key_valid per accepted press, whatever the hold duration. key_valid never asserts while key_held is already 1.
- A second key pressed while one is held reads as MULTI, counts toward release, and produces no pulse for the second key.
- cnt saturation cannot occur (DEBOUNCE_SCANS <= 15).

Test Plan:
(Use SCAN_DIV=4, DEBOUNCE_SCANS=3; frame=16 cycles. Bench keypad model: col[c]=0 iff row[r]=0 and key (r,c) is pressed.)
- Reset/rotation: deassert rst_n -> row=1110, outputs 0; row=1101 after 4 cycles, 1011 after 8, 0111 after 12, 1110 after 16.
- Clean press: hold key (1,2) for 6 frames -> exactly one key_valid pulse, key_code=6, key_held=1 from the 3rd frame end; release -> key_held=0 three frame ends after the first empty frame.
- Bounce reject: hold key (3,3) for 2 frames, release -> no key_valid, key_code stays at its previous value, key_held=0.
- Ghost reject: press keys (1,1) and (2,2) together for 6 frames -> no key_valid, key_held=0.
- Release glitch: hold key (0,0) for 10 frames with a 1-frame dropout at frame 6 -> one key_valid total, key_code=0, key_held stays 1 through the dropout.
- Async reset: assert rst_n=0 mid-PRESSED, between clock edges -> row=1110, key_held=0, key_code=0 immediately; after release of reset, with the key still held, a new press is accepted after 3 frames (one pulse).
